pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. It sequences the fetch stage after reset and generates all stall and flush strobes for the PC, IF/ID and ID/EX registers. Three hazard sources are resolved here: load-use, taken branches resolved in EX, and HI/LO conflicts with the multi-cycle multiplier/divider. Its `pc_stall` and `fetch_en` outputs drive the PC stage's stop request and IM read enable.

## Interface
- `BOOT_CYCLES`, 2: cycles after reset release during which fetch stays disabled (≥1).
- `MUL_CYCLES`, 5: busy cycles of an accepted multiply (≥1).
- `DIV_CYCLES`, 32: busy cycles of an accepted divide (≥1).

Ports (direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs`, `id_rt` in 5: source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1: the ID instruction actually reads that source.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_rd` in 5: destination register of the EX instruction.
- `ex_br_taken` in 1: branch/jump resolved taken in EX this cycle.
- `id_mdu_start` in 1: ID instruction is mult/multu/div/divu.
- `id_mdu_div` in 1: qualifies `id_mdu_start`; 1 = divide.
- `id_hilo_read` in 1: ID instruction is mfhi/mflo.
- `fetch_en` out 1: IM read enable; 0 holds the PC at its reset vector.
- `pc_stall` out 1: hold the PC.
- `ifid_stall` out 1: hold IF/ID.
- `ifid_flush` out 1: clear IF/ID to a bubble.
- `idex_flush` out 1: clear ID/EX to a bubble.
- `mdu_busy` out 1: the multiplier/divider is executing.

## Operation
- FSM states:
  - BOOT: `fetch_en`=0, `pc_stall`=1, `ifid_flush`=1, `idex_flush`=1. The boot counter counts BOOT_CYCLES, then moves to RUN.
  - RUN: `fetch_en`=1; hazard logic is active.
- Load-use hazard:
  - Condition: `ex_mem_read` && `ex_rd`≠0 && ((`id_uses_rs` && `id_rs`==`ex_rd`) || (`id_uses_rt` && `id_rt`==`ex_rd`)).
  - Response: `pc_stall`=1, `ifid_stall`=1, `idex_flush`=1.
- MDU hazard:
  - Condition: `mdu_busy` && (`id_hilo_read` || `id_mdu_start`).
  - Response: same three strobes as load-use.
- MDU accept:
  - Condition: RUN, `id_mdu_start`, no hazard of any kind, no `ex_br_taken`.
  - Action: load the busy counter with DIV_CYCLES or MUL_CYCLES.
  - `mdu_busy`=1 while the counter is nonzero; the counter decrements each cycle.
- Branch: `ex_br_taken` forces `ifid_flush`=1 and `idex_flush`=1, and forces `pc_stall`=0 and `ifid_stall`=0 so the PC loads the target.
- Priority, highest first: BOOT > branch > load-use/MDU stall.
- Counter width: $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).

## Timing
- Reset values: state=BOOT, `fetch_en`=0, `mdu_busy`=0, boot counter=0, busy counter=0.
  - Because state=BOOT, the BOOT strobe values apply during and after reset: `pc_stall`=1, `ifid_flush`=1, `idex_flush`=1, `ifid_stall`=0.
- Boot sequence: `rst` falls before edge E0. `fetch_en` rises after edge E(BOOT_CYCLES−1), i.e. exactly BOOT_CYCLES cycles after release.
- Stall/flush strobes are combinational from inputs and state, valid in the same cycle. There is no added latency.
- `mdu_busy` rises the cycle after the accept edge. It stays high for exactly N cycles.
- A dependent `mfhi` held in ID proceeds in the first cycle `mdu_busy`=0.
- Taken branch while `mdu_busy`: the counter keeps running, because the op already left ID.
- Taken branch while `id_mdu_start`: no accept, because the ID instruction is squashed.
- A load-use hazard and an MDU hazard in the same cycle produce one stall cycle's strobes; they do not double-count.
- `rst` mid-operation: next edge returns to BOOT and clears both counters. An in-flight MDU op is abandoned.

## Configuration
- Macro: `PIPE_CTRL_MDU_STALL_EN`.
- Defined: MDU busy counter and MDU hazard logic are present as described above.
- Undefined:
  - The MDU assumes a single-cycle unit; `mdu_busy` is tied to 0.
  - `id_mdu_start`, `id_mdu_div` and `id_hilo_read` are ignored.
  - MUL_CYCLES and DIV_CYCLES are unused.

## Structure
- Shared package `pipe_pkg` holds:
  - FSM state typedef {BOOT, RUN};
  - register-zero constant `REG_ZERO`=5'd0;
  - `RESET_VECTOR`=32'h3000, for consumers of `fetch_en`.
- One sub-module, `mdu_busy_cnt`: loadable down-counter with busy flag.
- The FSM and hazard compare logic stay in `pipe_ctrl`.

## Test plan
- Boot: `rst`=1 for 3 cycles, then 0 → `fetch_en`=0 for 2 cycles, then 1. `pc_stall`, `ifid_flush` and `idex_flush` are 1 during BOOT.
- Load-use: `ex_mem_read`=1, `ex_rd`=8, `id_rs`=8, `id_uses_rs`=1 → `pc_stall`, `ifid_stall` and `idex_flush` are 1 for one cycle.
  - With `ex_rd`=0 → no strobe.
- Branch over load-use: both conditions in one cycle → `ifid_flush`=1, `idex_flush`=1, `pc_stall`=0, `ifid_stall`=0.
- Divide: accept `div` (DIV_CYCLES=32), then hold `mfhi` in ID → `mdu_busy` is high for 32 cycles and the stall strobes are high throughout. `mfhi` proceeds in cycle 33.
- Mid-op reset: accept `mult`, assert `rst` 2 cycles later → `mdu_busy`=0 after the next edge and state is BOOT.
- Macro undefined: repeat the divide scenario → `mdu_busy` is never 1 and no stall occurs.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [31:0] RESET_VECTOR = 32'h3000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_busy_cnt.sv
// Loadable down-counter that reports the multiplier/divider as busy while nonzero.
module mdu_busy_cnt #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             busy
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: boot sequencing plus load-use, branch and HI/LO stall/flush strobes.
// The multi-cycle MDU tracking is built only when PIPE_CTRL_MDU_STALL_EN is defined.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int MUL_CYCLES  = 5,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       ex_br_taken,
    input  logic       id_mdu_start,
    input  logic       id_mdu_div,
    input  logic       id_hilo_read,
    output logic       fetch_en,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       mdu_busy
);

    localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [BOOT_W-1:0] boot_cnt;
    logic              load_use;
    logic              mdu_hazard;
    logic              hazard;

    assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

    assign hazard = load_use || mdu_hazard;

`ifdef PIPE_CTRL_MDU_STALL_EN
    localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);

    logic             mdu_accept;
    logic [CNT_W-1:0] mdu_load_val;

    assign mdu_hazard   = mdu_busy && (id_hilo_read || id_mdu_start);
    // A squashed (branch) or stalled MDU op in ID must not start the unit.
    assign mdu_accept   = (state == RUN) && id_mdu_start && !hazard && !ex_br_taken;
    assign mdu_load_val = id_mdu_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);

    mdu_busy_cnt #(
        .WIDTH(CNT_W)
    ) u_mdu_busy_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (mdu_accept),
        .load_val (mdu_load_val),
        .busy     (mdu_busy)
    );
`else
    localparam int unused_cycles = MUL_CYCLES + DIV_CYCLES;

    logic unused_mdu_inputs;

    assign unused_mdu_inputs = &{1'b0, id_mdu_start, id_mdu_div, id_hilo_read};
    assign mdu_hazard        = 1'b0;
    assign mdu_busy          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            boot_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == BOOT) begin
                boot_cnt <= boot_cnt + 1'b1;
            end
        end
    end

    // Branch squashes both younger instructions and lets the PC load the target,
    // so it overrides any stall request.
    always_comb begin
        state_next = state;
        fetch_en   = 1'b0;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        case (state)
            BOOT: begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (boot_cnt == BOOT_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                fetch_en = 1'b1;
                if (ex_br_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (hazard) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl; expectations adapt to PIPE_CTRL_MDU_STALL_EN.
module tb_pipe_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rs;
        logic       id_uses_rt;
        logic       ex_mem_read;
        logic [4:0] ex_rd;
        logic       ex_br_taken;
        logic       id_mdu_start;
        logic       id_mdu_div;
        logic       id_hilo_read;
    } stim_t;

`ifdef PIPE_CTRL_MDU_STALL_EN
    localparam logic M = 1'b1;
`else
    localparam logic M = 1'b0;
`endif

    // Output vector order: {fetch_en, pc_stall, ifid_stall, ifid_flush, idex_flush, mdu_busy}
    localparam logic [5:0] E_BOOT  = 6'b010110;
    localparam logic [5:0] E_RUN   = 6'b100000;
    localparam logic [5:0] E_STALL = 6'b111010;
    localparam logic [5:0] E_BR    = 6'b100110;
    localparam logic [5:0] E_BUSY  = {5'b00000, M};

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_br_taken;
    logic       id_mdu_start;
    logic       id_mdu_div;
    logic       id_hilo_read;
    logic       fetch_en;
    logic       pc_stall;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_flush;
    logic       mdu_busy;

    logic [5:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    pipe_ctrl #(
        .BOOT_CYCLES (2),
        .MUL_CYCLES  (5),
        .DIV_CYCLES  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_br_taken  (ex_br_taken),
        .id_mdu_start (id_mdu_start),
        .id_mdu_div   (id_mdu_div),
        .id_hilo_read (id_hilo_read),
        .fetch_en     (fetch_en),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .mdu_busy     (mdu_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's inputs just after the rising edge and queue what that cycle must show.
    task automatic applyStimulus(input stim_t s, input logic [5:0] exp, input string name);
        @(posedge clk);
        #1;
        rst          = s.rst;
        id_rs        = s.id_rs;
        id_rt        = s.id_rt;
        id_uses_rs   = s.id_uses_rs;
        id_uses_rt   = s.id_uses_rt;
        ex_mem_read  = s.ex_mem_read;
        ex_rd        = s.ex_rd;
        ex_br_taken  = s.ex_br_taken;
        id_mdu_start = s.id_mdu_start;
        id_mdu_div   = s.id_mdu_div;
        id_hilo_read = s.id_hilo_read;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(input logic [5:0] exp, input string name);
        logic [5:0] act;
        act = {fetch_en, pc_stall, ifid_stall, ifid_flush, idex_flush, mdu_busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (fetch,pcs,ifs,iff,idf,busy) at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are combinational, so the falling edge sees the settled cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front(), name_q.pop_front());
        end
    end

    initial begin
        stim_t s;
        stim_t idle;
        idle = '0;

        rst = 1'b1;
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; ex_br_taken = 1'b0;
        id_mdu_start = 1'b0; id_mdu_div = 1'b0; id_hilo_read = 1'b0;

        s = idle; s.rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(s, E_BOOT, "reset_boot");
        applyStimulus(idle, E_BOOT, "boot_cycle0");
        applyStimulus(idle, E_BOOT, "boot_cycle1");
        applyStimulus(idle, E_RUN, "run_first");

        s = idle; s.ex_mem_read = 1'b1; s.ex_rd = 5'd8; s.id_rs = 5'd8; s.id_uses_rs = 1'b1;
        applyStimulus(s, E_STALL, "load_use_rs");
        applyStimulus(idle, E_RUN, "after_load_use");

        s = idle; s.ex_mem_read = 1'b1; s.ex_rd = 5'd0; s.id_rs = 5'd0; s.id_uses_rs = 1'b1;
        applyStimulus(s, E_RUN, "load_use_r0");

        s = idle; s.ex_mem_read = 1'b1; s.ex_rd = 5'd9; s.id_rt = 5'd9; s.id_uses_rt = 1'b1;
        applyStimulus(s, E_STALL, "load_use_rt");

        s = idle; s.ex_mem_read = 1'b1; s.ex_rd = 5'd9; s.id_rt = 5'd9; s.id_uses_rt = 1'b0;
        applyStimulus(s, E_RUN, "rt_not_used");

        s = idle; s.ex_mem_read = 1'b0; s.ex_rd = 5'd8; s.id_rs = 5'd8; s.id_uses_rs = 1'b1;
        applyStimulus(s, E_RUN, "no_load_match");

        s = idle; s.ex_mem_read = 1'b1; s.ex_rd = 5'd8; s.id_rs = 5'd8; s.id_uses_rs = 1'b1;
        s.ex_br_taken = 1'b1;
        applyStimulus(s, E_BR, "branch_over_load_use");

        s = idle; s.ex_br_taken = 1'b1;
        applyStimulus(s, E_BR, "branch_alone");

        // Divide accepted, then a dependent mfhi waits in ID.
        s = idle; s.id_mdu_start = 1'b1; s.id_mdu_div = 1'b1;
        applyStimulus(s, E_RUN, "div_accept");
        s = idle; s.id_hilo_read = 1'b1;
        for (int i = 0; i < 32; i++) applyStimulus(s, M ? 6'b111011 : E_RUN, "div_mfhi_wait");
        applyStimulus(s, E_RUN, "div_mfhi_proceeds");

        // Multiply accepted; branch, combined hazards and a second start while busy.
        s = idle; s.id_mdu_start = 1'b1;
        applyStimulus(s, E_RUN, "mul_accept");
        s = idle; s.ex_br_taken = 1'b1;
        applyStimulus(s, E_BR | E_BUSY, "branch_while_busy");
        s = idle; s.ex_mem_read = 1'b1; s.ex_rd = 5'd4; s.id_rs = 5'd4; s.id_uses_rs = 1'b1;
        s.id_hilo_read = 1'b1;
        applyStimulus(s, E_STALL | E_BUSY, "load_use_and_mdu");
        s = idle; s.id_mdu_start = 1'b1;
        applyStimulus(s, M ? 6'b111011 : E_RUN, "start_while_busy");
        applyStimulus(idle, E_RUN | E_BUSY, "mul_busy4");
        applyStimulus(idle, E_RUN | E_BUSY, "mul_busy5");
        applyStimulus(idle, E_RUN, "mul_done");

        // A start squashed by a branch must not start the unit.
        s = idle; s.id_mdu_start = 1'b1; s.ex_br_taken = 1'b1;
        applyStimulus(s, E_BR, "branch_squash_start");
        applyStimulus(idle, E_RUN, "squash_not_busy");

        // Reset two cycles into a multiply abandons it.
        s = idle; s.id_mdu_start = 1'b1;
        applyStimulus(s, E_RUN, "midop_accept");
        applyStimulus(idle, E_RUN | E_BUSY, "midop_busy1");
        applyStimulus(idle, E_RUN | E_BUSY, "midop_busy2");
        s = idle; s.rst = 1'b1;
        applyStimulus(s, E_RUN | E_BUSY, "midop_rst_cycle");
        applyStimulus(s, E_BOOT, "midop_rst_boot");
        applyStimulus(idle, E_BOOT, "reboot0");
        applyStimulus(idle, E_BOOT, "reboot1");
        applyStimulus(idle, E_RUN, "rerun");

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
